// File: rtl/cache_port_arbiter.sv
// Round-robin front end that funnels N request/valid 4-phase channels onto one
// cache slave port and returns the slave's read data to the winning channel.
module cache_port_arbiter #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int OP_W   = 2,
    parameter int IDX_W  = $clog2(N_CH)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_CH-1:0]          m_req,
    input  logic [N_CH*OP_W-1:0]     m_op,
    input  logic [N_CH*ADDR_W-1:0]   m_addr,
    input  logic [N_CH*DATA_W-1:0]   m_wdata,
    output logic [N_CH-1:0]          m_valid,
    output logic [DATA_W-1:0]        m_rdata,
    output logic                     s_req,
    output logic [OP_W-1:0]          s_op,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_wdata,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_rdata,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESPOND} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [IDX_W-1:0]    gnt_reg, gnt_next;
    logic [N_CH-1:0]     m_valid_reg, m_valid_next;
    logic [DATA_W-1:0]   m_rdata_reg, m_rdata_next;
    logic                s_req_reg, s_req_next;
    logic [OP_W-1:0]     s_op_reg, s_op_next;
    logic [ADDR_W-1:0]   s_addr_reg, s_addr_next;
    logic [DATA_W-1:0]   s_wdata_reg, s_wdata_next;
    logic                busy_reg, busy_next;

    logic [OP_W-1:0]     ch_op    [N_CH];
    logic [ADDR_W-1:0]   ch_addr  [N_CH];
    logic [DATA_W-1:0]   ch_wdata [N_CH];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign ch_op[gi]    = m_op[gi*OP_W +: OP_W];
        assign ch_addr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
        assign ch_wdata[gi] = m_wdata[gi*DATA_W +: DATA_W];
    end

    // Circular priority search: scanning offsets high to low leaves the
    // requester closest at or after ptr as the pick.
    logic [IDX_W-1:0] pick, cand;
    logic             any_req;

    always_comb begin
        pick    = ptr_reg;
        cand    = '0;
        any_req = |m_req;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_reg) + k) % N_CH);
            if (m_req[cand]) pick = cand;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gnt_reg     <= '0;
            m_valid_reg <= '0;
            m_rdata_reg <= '0;
            s_req_reg   <= 1'b0;
            s_op_reg    <= '0;
            s_addr_reg  <= '0;
            s_wdata_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_reg     <= gnt_next;
            m_valid_reg <= m_valid_next;
            m_rdata_reg <= m_rdata_next;
            s_req_reg   <= s_req_next;
            s_op_reg    <= s_op_next;
            s_addr_reg  <= s_addr_next;
            s_wdata_reg <= s_wdata_next;
            busy_reg    <= busy_next;
        end
    end

    // A still-high s_valid in IDLE is a leftover from reset and blocks issue.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!s_valid && any_req) state_next = ISSUE;
            ISSUE:   if (s_valid)             state_next = DRAIN;
            DRAIN:   if (!s_valid)            state_next = RESPOND;
            RESPOND: if (!m_req[gnt_reg])     state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_comb begin
        ptr_next     = ptr_reg;
        gnt_next     = gnt_reg;
        m_valid_next = m_valid_reg;
        m_rdata_next = m_rdata_reg;
        s_req_next   = s_req_reg;
        s_op_next    = s_op_reg;
        s_addr_next  = s_addr_reg;
        s_wdata_next = s_wdata_reg;
        busy_next    = busy_reg;
        case (state_reg)
            IDLE: begin
                if (!s_valid && any_req) begin
                    gnt_next     = pick;
                    ptr_next     = (pick == IDX_W'(N_CH - 1)) ? '0 : pick + 1'b1;
                    s_req_next   = 1'b1;
                    s_op_next    = ch_op[pick];
                    s_addr_next  = ch_addr[pick];
                    s_wdata_next = ch_wdata[pick];
                    busy_next    = 1'b1;
                end
            end
            ISSUE: begin
                if (s_valid) begin
                    m_rdata_next = s_rdata;
                    s_req_next   = 1'b0;
                end
            end
            DRAIN: begin
                if (!s_valid) m_valid_next = N_CH'(1) << gnt_reg;
            end
            RESPOND: begin
                if (!m_req[gnt_reg]) begin
                    m_valid_next = '0;
                    busy_next    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign m_valid   = m_valid_reg;
    assign m_rdata   = m_rdata_reg;
    assign s_req     = s_req_reg;
    assign s_op      = s_op_reg;
    assign s_addr    = s_addr_reg;
    assign s_wdata   = s_wdata_reg;
    assign grant_idx = gnt_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed plus randomized bench for cache_port_arbiter; a transaction-level
// round-robin model supplies the expected grant order and returned data.
module tb_cache_port_arbiter;
    localparam int N_CH   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int OP_W   = 2;
    localparam int IDX_W  = 2;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [N_CH-1:0]        m_req;
    logic [N_CH*OP_W-1:0]   m_op;
    logic [N_CH*ADDR_W-1:0] m_addr;
    logic [N_CH*DATA_W-1:0] m_wdata;
    logic [N_CH-1:0]        m_valid;
    logic [DATA_W-1:0]      m_rdata;
    logic                   s_req;
    logic [OP_W-1:0]        s_op;
    logic [ADDR_W-1:0]      s_addr;
    logic [DATA_W-1:0]      s_wdata;
    logic                   s_valid;
    logic [DATA_W-1:0]      s_rdata;
    logic [IDX_W-1:0]       grant_idx;
    logic                   busy;

    cache_port_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .m_req(m_req), .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_valid(m_valid), .m_rdata(m_rdata),
        .s_req(s_req), .s_op(s_op), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_valid(s_valid), .s_rdata(s_rdata),
        .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: round-robin pointer and the current transaction.
    int                ptr_m;
    int                g_cur;
    logic [OP_W-1:0]   exp_op;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int ref_pick(input logic [N_CH-1:0] req, input int p);
        for (int k = 0; k < N_CH; k++) begin
            int idx;
            idx = (p + k) % N_CH;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        chk("valid_onehot0", 64'($onehot0(m_valid)), 64'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_req   = '0;
        s_valid = 1'b0;
        s_rdata = '0;
        tick();
        tick();
        chk("rst_s_req", s_req, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m_rdata", m_rdata, 0);
        reset_n = 1'b1;
        ptr_m   = 0;
    endtask

    task automatic grant_phase();
        g_cur     = ref_pick(m_req, ptr_m);
        exp_op    = m_op[g_cur*OP_W +: OP_W];
        exp_addr  = m_addr[g_cur*ADDR_W +: ADDR_W];
        exp_wdata = m_wdata[g_cur*DATA_W +: DATA_W];
        tick();
        chk("grant_s_req", s_req, 1);
        chk("grant_idx", grant_idx, 64'(g_cur));
        chk("grant_s_op", s_op, exp_op);
        chk("grant_s_addr", s_addr, exp_addr);
        chk("grant_s_wdata", s_wdata, exp_wdata);
        chk("grant_busy", busy, 1);
        ptr_m = (g_cur + 1) % N_CH;
    endtask

    task automatic finish_phase(input int lat, input int drain, input int hold,
                                input logic [DATA_W-1:0] rd, input bit rearm);
        repeat (lat - 1) begin
            tick();
            chk("issue_s_req", s_req, 1);
            chk("issue_s_addr", s_addr, exp_addr);
            chk("issue_grant", grant_idx, 64'(g_cur));
        end
        s_valid = 1'b1;
        s_rdata = rd;
        tick();
        chk("resp_s_req_low", s_req, 0);
        chk("resp_m_rdata", m_rdata, rd);
        chk("resp_no_valid", m_valid, 0);
        s_rdata = DATA_W'($urandom);
        repeat (drain) begin
            tick();
            chk("drain_no_valid", m_valid, 0);
        end
        s_valid = 1'b0;
        tick();
        chk("valid_rise", m_valid, 64'(1 << g_cur));
        chk("valid_rdata", m_rdata, rd);
        chk("valid_busy", busy, 1);
        repeat (hold) begin
            tick();
            chk("valid_hold", m_valid, 64'(1 << g_cur));
        end
        m_req[g_cur] = 1'b0;
        tick();
        chk("valid_fall", m_valid, 0);
        chk("busy_fall", busy, 0);
        chk("idle_s_req", s_req, 0);
        if (rearm) m_req[g_cur] = 1'b1;
    endtask

    initial begin
        m_op    = '0;
        m_addr  = '0;
        m_wdata = '0;
        do_reset();
        tick();
        chk("idle_no_issue", s_req, 0);

        // ch0 and ch3 together from ptr=0: ch0 then ch3, pointer wraps to 0
        m_addr[0*ADDR_W +: ADDR_W] = 32'h100;
        m_addr[3*ADDR_W +: ADDR_W] = 32'h300;
        m_req = 4'b1001;
        grant_phase();
        chk("two_first", grant_idx, 0);
        finish_phase(2, 0, 1, 8'h11, 1'b0);
        grant_phase();
        chk("two_second", grant_idx, 3);
        finish_phase(2, 0, 0, 8'h33, 1'b0);

        // single read on ch2, latency 3
        m_addr[2*ADDR_W +: ADDR_W] = 32'h0000_1234;
        m_op[2*OP_W +: OP_W] = 2'b01;
        m_req = 4'b0100;
        grant_phase();
        chk("single_grant", grant_idx, 2);
        chk("single_addr", s_addr, 32'h1234);
        finish_phase(3, 0, 0, 8'hA5, 1'b0);

        // address changes after grant must not reach the slave
        m_addr[1*ADDR_W +: ADDR_W] = 32'h10;
        m_req = 4'b0010;
        grant_phase();
        m_addr[1*ADDR_W +: ADDR_W] = 32'h20;
        finish_phase(3, 1, 0, 8'h5C, 1'b0);

        // requester drops early: one-cycle valid, then idle
        m_req = 4'b0010;
        grant_phase();
        m_req[1] = 1'b0;
        finish_phase(2, 1, 0, 8'h77, 1'b0);

        // fairness with all channels requesting continuously
        do_reset();
        m_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            grant_phase();
            chk("fair_order", grant_idx, 64'(i % N_CH));
            finish_phase(1, 0, 0, DATA_W'($urandom), 1'b1);
        end

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            m_req = m_req | N_CH'($urandom);
            if (m_req == '0) m_req[$urandom_range(N_CH - 1, 0)] = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                m_op[c*OP_W +: OP_W]       = OP_W'($urandom_range(3, 0));
                m_addr[c*ADDR_W +: ADDR_W] = $urandom;
                m_wdata[c*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            grant_phase();
            m_addr[g_cur*ADDR_W +: ADDR_W] = $urandom;
            if ($urandom_range(3, 0) == 0) begin
                m_req[g_cur] = 1'b0;
                finish_phase($urandom_range(4, 1), $urandom_range(2, 0), 0, DATA_W'($urandom), 1'b0);
            end else begin
                finish_phase($urandom_range(4, 1), $urandom_range(2, 0), $urandom_range(2, 0),
                             DATA_W'($urandom), 1'b0);
            end
        end

        // reset during ISSUE with the slave still responding
        m_req = 4'b0010;
        grant_phase();
        tick();
        s_valid = 1'b1;
        reset_n = 1'b0;
        tick();
        chk("rst_issue_s_req", s_req, 0);
        chk("rst_issue_m_valid", m_valid, 0);
        chk("rst_issue_busy", busy, 0);
        chk("rst_issue_grant", grant_idx, 0);
        reset_n = 1'b1;
        ptr_m   = 0;
        repeat (2) begin
            tick();
            chk("blocked_s_req", s_req, 0);
            chk("blocked_busy", busy, 0);
        end
        s_valid = 1'b0;
        grant_phase();
        finish_phase(2, 0, 0, 8'h3C, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
